// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline stage built around a two-entry skid buffer.
// The head (main) entry drives the MEM-facing outputs; the skid entry catches
// a beat accepted while MEM stalls, so in_ready never depends on out_ready.
// A synchronous flush empties the stage. A saturating counter tracks the
// number of cycles in which MEM back-pressured a valid beat.
//
// Handshake: a beat moves on a rising clk edge exactly when valid and ready
// are both high in the cycle before that edge. The sender holds valid and
// data stable until it sees ready. The receiver may change ready freely.
// Here in_ready depends only on registered occupancy. out_valid likewise
// depends only on registered occupancy.
module exmem_skid_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic            WB_EN_IN,
    input  logic            MEM_R_EN_IN,
    input  logic            MEM_W_EN_IN,
    input  logic [XLEN-1:0] PCIn,
    input  logic [XLEN-1:0] ALUResIn,
    input  logic [XLEN-1:0] STValIn,
    input  logic [REGW-1:0] destIn,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            WB_EN,
    output logic            MEM_R_EN,
    output logic            MEM_W_EN,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] ALURes,
    output logic [XLEN-1:0] STVal,
    output logic [REGW-1:0] dest,
    output logic [CNTW-1:0] stall_cnt
);

    // Bit 0 is the main-entry valid bit, bit 1 the skid-entry valid bit.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    typedef struct packed {
        logic            wb_en;
        logic            mem_r_en;
        logic            mem_w_en;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] st_val;
        logic [REGW-1:0] dest;
    } beat_t;

    state_t state;
    beat_t  in_beat;
    beat_t  main_q;
    beat_t  skid_q;
    logic   accept;
    logic   consume;

    assign in_beat = {WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, PCIn, ALUResIn, STValIn, destIn};

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // Occupancy FSM and entry storage; flush overrides every handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= ONE;
                        main_q <= in_beat;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_q <= in_beat;
                    end else if (accept) begin
                        state  <= TWO;
                        skid_q <= in_beat;
                    end else if (consume) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Saturating count of cycles where a valid head is back-pressured by MEM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    // Control bits are gated so a bubble can never write memory or registers;
    // data fields simply show the last loaded head.
    assign WB_EN    = out_valid & main_q.wb_en;
    assign MEM_R_EN = out_valid & main_q.mem_r_en;
    assign MEM_W_EN = out_valid & main_q.mem_w_en;
    assign PC       = main_q.pc;
    assign ALURes   = main_q.alu_res;
    assign STVal    = main_q.st_val;
    assign dest     = main_q.dest;

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Bench for exmem_skid_stage: scenario tasks with inline checks, plus a
// negedge scoreboard holding expected beats in arrival order and an
// independent occupancy/stall model.
module tb_exmem_skid_stage;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int CNTW = 16;
    localparam int W    = 3 + 3 * XLEN + REGW;

    logic            clk;
    logic            rstn;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic            WB_EN_IN;
    logic            MEM_R_EN_IN;
    logic            MEM_W_EN_IN;
    logic [XLEN-1:0] PCIn;
    logic [XLEN-1:0] ALUResIn;
    logic [XLEN-1:0] STValIn;
    logic [REGW-1:0] destIn;
    logic            out_valid;
    logic            out_ready;
    logic            WB_EN;
    logic            MEM_R_EN;
    logic            MEM_W_EN;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] ALURes;
    logic [XLEN-1:0] STVal;
    logic [REGW-1:0] dest;
    logic [CNTW-1:0] stall_cnt;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [W-1:0]    exp_q[$];
    logic [CNTW-1:0] exp_stall = '0;
    logic            sb_en = 1'b0;
    logic            model_valid;
    logic            model_ready;
    logic [W-1:0]    got_beat;

    exmem_skid_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN),
        .MEM_W_EN_IN(MEM_W_EN_IN), .PCIn(PCIn), .ALUResIn(ALUResIn),
        .STValIn(STValIn), .destIn(destIn), .out_valid(out_valid),
        .out_ready(out_ready), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
        .MEM_W_EN(MEM_W_EN), .PC(PC), .ALURes(ALURes), .STVal(STVal),
        .dest(dest), .stall_cnt(stall_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [XLEN-1:0] pc, input logic [REGW-1:0] d,
                              input logic wb, input logic mr, input logic mw);
        in_valid    = 1'b1;
        PCIn        = pc;
        ALUResIn    = pc ^ 32'hA5A5_0000;
        STValIn     = ~pc;
        destIn      = d;
        WB_EN_IN    = wb;
        MEM_R_EN_IN = mr;
        MEM_W_EN_IN = mw;
    endtask

    task automatic drive_random_beat();
        in_valid    = 1'b1;
        PCIn        = $urandom();
        ALUResIn    = $urandom();
        STValIn     = $urandom();
        destIn      = REGW'($urandom_range(0, 31));
        WB_EN_IN    = 1'($urandom_range(0, 1));
        MEM_R_EN_IN = 1'($urandom_range(0, 1));
        MEM_W_EN_IN = 1'($urandom_range(0, 1));
    endtask

    // ---------------- scoreboard ----------------
    // Checks occupancy, stall count and gating each cycle, compares each
    // consumed head with the oldest expected beat, then advances the model.
    always @(negedge clk) begin
        if (sb_en) begin
            model_valid = (exp_q.size() != 0);
            model_ready = (exp_q.size() < 2);
            assert_cnt++;
            if (out_valid !== model_valid)
                $display("FAIL sb_out_valid: got %b expected %b at %0t", out_valid, model_valid, $time);
            assert_cnt++;
            if (in_ready !== model_ready)
                $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, model_ready, $time);
            assert_cnt++;
            if (stall_cnt !== exp_stall)
                $display("FAIL sb_stall_cnt: got %0d expected %0d at %0t", stall_cnt, exp_stall, $time);
            if (out_valid !== model_valid || in_ready !== model_ready || stall_cnt !== exp_stall)
                fail_cnt++;
            if (!out_valid) begin
                assert_cnt++;
                if ({WB_EN, MEM_R_EN, MEM_W_EN} !== 3'b000) begin
                    fail_cnt++;
                    $display("FAIL sb_bubble_ctrl: got %b expected 000 at %0t",
                             {WB_EN, MEM_R_EN, MEM_W_EN}, $time);
                end
            end
            if (!rstn) begin
                exp_q.delete();
                exp_stall = '0;
            end else begin
                if (model_valid && out_ready) begin
                    got_beat = {WB_EN, MEM_R_EN, MEM_W_EN, PC, ALURes, STVal, dest};
                    assert_cnt++;
                    if (got_beat !== exp_q[0]) begin
                        fail_cnt++;
                        $display("FAIL sb_head_beat: got %h expected %h at %0t", got_beat, exp_q[0], $time);
                    end
                    void'(exp_q.pop_front());
                end
                if (model_valid && !out_ready && exp_stall != {CNTW{1'b1}})
                    exp_stall = exp_stall + 1'b1;
                if (flush)
                    exp_q.delete();
                else if (in_valid && model_ready)
                    exp_q.push_back({WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, PCIn, ALUResIn, STValIn, destIn});
            end
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        assert_cnt++;
        if ({out_valid, WB_EN, MEM_R_EN, MEM_W_EN} !== 4'b0000) begin
            fail_cnt++;
            $display("FAIL reset_ctrl: got %b expected 0000", {out_valid, WB_EN, MEM_R_EN, MEM_W_EN});
        end
        assert_cnt++;
        if ({PC, ALURes, STVal, dest} !== '0) begin
            fail_cnt++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected all 0", PC, ALURes, STVal, dest);
        end
        assert_cnt++;
        if (stall_cnt !== '0) begin
            fail_cnt++;
            $display("FAIL reset_stall: got %0d expected 0", stall_cnt);
        end
        rstn = 1'b1;
        tick();
        assert_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            assert_cnt++;
            if (in_ready !== 1'b1) begin
                fail_cnt++;
                $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", k, in_ready);
            end
            if (k >= 1) begin
                assert_cnt++;
                if (out_valid !== 1'b1 || PC !== 32'h100 + 32'(4 * (k - 1)) || dest !== REGW'(k - 1)) begin
                    fail_cnt++;
                    $display("FAIL b2b_pc: cycle %0d got v=%b pc=%h dest=%0d expected v=1 pc=%h dest=%0d",
                             k, out_valid, PC, dest, 32'h100 + 32'(4 * (k - 1)), k - 1);
                end
            end
            if (k < 8) drive_beat(32'h100 + 32'(4 * k), REGW'(k), 1'b1, 1'b0, 1'b0);
            else in_valid = 1'b0;
            tick();
        end
        assert_cnt++;
        if (out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_skid();
        do_reset();
        out_ready = 1'b0;
        drive_beat(32'h200, 5'd1, 1'b0, 1'b0, 1'b1);
        tick();
        assert_cnt++;
        if (out_valid !== 1'b1 || MEM_W_EN !== 1'b1 || PC !== 32'h200 || in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
            fail_cnt++;
            $display("FAIL skid_one: got v=%b mw=%b pc=%h rdy=%b st=%0d expected 1/1/200/1/0",
                     out_valid, MEM_W_EN, PC, in_ready, stall_cnt);
        end
        drive_beat(32'h204, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            assert_cnt++;
            if (in_ready !== 1'b0 || stall_cnt !== 16'(s) || PC !== 32'h200) begin
                fail_cnt++;
                $display("FAIL skid_two: step %0d got rdy=%b st=%0d pc=%h expected 0/%0d/200",
                         s, in_ready, stall_cnt, PC, s);
            end
            if (s < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        assert_cnt++;
        if (out_valid !== 1'b1 || PC !== 32'h204 || MEM_W_EN !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'd3) begin
            fail_cnt++;
            $display("FAIL skid_release: got v=%b pc=%h mw=%b rdy=%b st=%0d expected 1/204/0/1/3",
                     out_valid, PC, MEM_W_EN, in_ready, stall_cnt);
        end
        tick();
        assert_cnt++;
        if (out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL skid_empty: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_beat(32'h300, 5'd3, 1'b0, 1'b0, 1'b1);
        tick();
        drive_beat(32'h304, 5'd4, 1'b0, 1'b0, 1'b1);
        tick();
        drive_beat(32'h308, 5'd5, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        assert_cnt++;
        if (out_valid !== 1'b0 || MEM_W_EN !== 1'b0 || in_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL flush_empty: got v=%b mw=%b rdy=%b expected 0/0/1", out_valid, MEM_W_EN, in_ready);
        end
        drive_beat(32'h30C, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        assert_cnt++;
        if (out_valid !== 1'b1 || PC !== 32'h30C || in_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL flush_next: got v=%b pc=%h rdy=%b expected 1/30c/1", out_valid, PC, in_ready);
        end
        out_ready = 1'b1;
        tick();
        assert_cnt++;
        if (out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL flush_alone: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        drive_beat(32'h400, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (70000) tick();
        assert_cnt++;
        if (stall_cnt !== 16'hFFFF) begin
            fail_cnt++;
            $display("FAIL sat_value: got %0d expected 65535", stall_cnt);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        assert_cnt++;
        if (stall_cnt !== 16'hFFFF || out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL sat_after_flush: got st=%0d v=%b expected 65535/0", stall_cnt, out_valid);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int cycles = 0;
        while (sent < 1000 && cycles < 20000) begin
            if ($urandom_range(0, 9) < 7) drive_random_beat();
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 9) < 6);
            if (in_valid && in_ready) sent++;
            tick();
            cycles++;
        end
        assert_cnt++;
        if (sent < 1000) begin
            fail_cnt++;
            $display("FAIL rand_budget: sent %0d beats expected 1000 within 20000 cycles", sent);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles = 0;
        while (out_valid && cycles < 10) begin
            tick();
            cycles++;
        end
        tick();
        assert_cnt++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL rand_drain: got pending=%0d out_valid=%b expected 0/0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_in_two();
        out_ready = 1'b0;
        drive_beat(32'h500, 5'd8, 1'b1, 1'b1, 1'b1);
        tick();
        drive_beat(32'h504, 5'd9, 1'b1, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        assert_cnt++;
        if (in_ready !== 1'b0 || stall_cnt === 16'd0) begin
            fail_cnt++;
            $display("FAIL rst2_setup: got rdy=%b st=%0d expected 0/nonzero", in_ready, stall_cnt);
        end
        rstn  = 1'b0;
        flush = 1'b1;
        tick();
        assert_cnt++;
        if ({out_valid, WB_EN, MEM_R_EN, MEM_W_EN} !== 4'b0000 || {PC, ALURes, STVal, dest} !== '0) begin
            fail_cnt++;
            $display("FAIL rst2_outputs: got v=%b ctrl=%b pc=%h alu=%h st=%h d=%0d expected all 0",
                     out_valid, {WB_EN, MEM_R_EN, MEM_W_EN}, PC, ALURes, STVal, dest);
        end
        assert_cnt++;
        if (stall_cnt !== 16'd0 || in_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL rst2_state: got st=%0d rdy=%b expected 0/1", stall_cnt, in_ready);
        end
        rstn  = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        WB_EN_IN = 1'b0; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0;
        PCIn = '0; ALUResIn = '0; STValIn = '0; destIn = '0;
        tick();
        sb_en = 1'b1;
        test_reset();
        test_back_to_back();
        test_skid();
        test_flush();
        test_saturation();
        test_random();
        test_reset_in_two();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/exmem_skid_stage.md
# exmem_skid_stage

Parametrised EX/MEM pipeline stage. It sits between the execute stage and the memory stage of the core. Beats move across a valid/ready handshake into a two-entry skid buffer, so back-pressure from MEM never drops or duplicates an EX result. It also adds a synchronous flush for branch and exception recovery, and a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- XLEN, 32, width of PC, ALU result and store value
- REGW, 5, width of destination register index
- CNTW, 16, width of stall counter

Ports:
- clk  in  1  clock; all state updates on posedge clk
- rstn  in  1  synchronous, active-low reset, sampled on posedge clk
- in_valid  in  1  EX presents a beat
- in_ready  out  1  stage can accept a beat
- flush  in  1  discard all held and incoming beats
- WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN  in  1 each  control bits of incoming beat
- PCIn, ALUResIn, STValIn  in  XLEN each  data of incoming beat
- destIn  in  REGW  destination index of incoming beat
- out_valid  out  1  stage presents a beat to MEM
- out_ready  in  1  MEM consumes the beat
- WB_EN, MEM_R_EN, MEM_W_EN  out  1 each  control bits of head beat, gated by out_valid
- PC, ALURes, STVal  out  XLEN each  data of head beat
- dest  out  REGW  destination index of head beat
- stall_cnt  out  CNTW  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage is a main register (head, drives outputs) and a skid register. State is EMPTY, ONE or TWO, encoded from the main/skid valid bits.
- Handshake definitions:
  - accept = in_valid & in_ready
  - consume = out_valid & out_ready
- in_ready = (state != TWO). It is combinational from registered state only and never depends on out_ready.
- out_valid = (state != EMPTY).
- Transitions when flush=0:
  - EMPTY: accept -> ONE, main <= input.
  - ONE, accept & consume: stay ONE, main <= input.
  - ONE, accept & !consume: go to TWO, skid <= input.
  - ONE, !accept & consume: go to EMPTY.
  - ONE, otherwise: hold.
  - TWO, consume: go to ONE, main <= skid.
  - TWO, otherwise: hold. No accept is possible in TWO because in_ready=0.
- Flush:
  - flush=1 has priority over all handshakes: next state is EMPTY and any input beat in that cycle is dropped.
  - MEM may still treat a beat shown in the flush cycle as consumed. Side effects are MEM's responsibility, and MEM must gate on flush.
- Outputs:
  - WB_EN, MEM_R_EN and MEM_W_EN are forced to 0 whenever out_valid=0. A bubble therefore never writes memory or the register file.
  - PC, ALURes, STVal and dest hold their last loaded value when empty.
- Ordering: beats leave in strict arrival order and none is lost or duplicated.
- stall_cnt increments by 1 on every cycle with out_valid & !out_ready, saturates at 2^CNTW-1, and is cleared only by reset. Flush does not clear it.

## Timing
- Reset (rstn=0 at posedge): state EMPTY. All outputs 0: out_valid, WB_EN, MEM_R_EN, MEM_W_EN, PC, ALURes, STVal, dest, stall_cnt. Skid contents are zeroed.
- in_ready=1 from the first cycle after reset.
- Reset mid-operation discards both entries with no partial output.
- Latency: a beat accepted at edge N is visible on the outputs with out_valid=1 after edge N.
- Throughput: 1 beat per cycle when out_ready stays 1.
- in_ready drops one cycle after the first unconsumed accept that fills the skid. It rises in the cycle after a consume from TWO.
- A beat sitting in TWO is presented the cycle after the head is consumed. There are no bubbles between back-to-back beats.
- Simultaneous accept and consume in ONE keeps occupancy constant.
- Simultaneous flush and reset: reset wins, and the result is identical.

## Test plan
- Reset, then 8 back-to-back beats (PCIn=0x100+4k, destIn=k) with out_ready=1 -> out_valid high from the cycle after the first beat; PC sequence 0x100..0x11C in order, one per cycle; in_ready never drops.
- Accept beat A (MEM_W_EN_IN=1), hold out_ready=0, offer beat B -> B accepted into skid, in_ready=0, stall_cnt counts 1,2,3…; raise out_ready -> A then B on consecutive cycles, in_ready=1 again.
- State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, MEM_W_EN=0, state EMPTY; next accepted beat appears alone.
- out_ready=0 held for 70000 cycles with CNTW=16 -> stall_cnt saturates at 65535 and stays there; flush leaves it unchanged.
- Randomized in_valid/out_ready with 1000 beats vs scoreboard -> exact order, no loss or duplication, control outputs 0 whenever out_valid=0.
- rstn=0 while in TWO -> all outputs 0 next cycle; stall_cnt=0; in_ready=1.
